// File: rtl/jtframe_sdram_rr_arb_if.sv
// jtframe_sdram_rr_arb_if: requester-side and controller-side signals of the four-way SDRAM arbiter
interface jtframe_sdram_rr_arb_if #(parameter int SDRAMW = 22);
  logic [3:0] req_rd, req_wr, req_ack, req_rdy, req_dst;
  logic [4*SDRAMW-1:0] req_addr;
  logic [63:0] req_din;
  logic [7:0] req_wrmask;
  logic sdram_ack, data_rdy, data_dst, sdram_rd, sdram_wr, busy, tmo_err;
  logic [SDRAMW-1:0] sdram_addr;
  logic [15:0] data_write;
  logic [1:0] sdram_wrmask;
  modport master (
    output req_rd, req_wr, req_addr, req_din, req_wrmask, sdram_ack, data_rdy, data_dst,
    input  req_ack, req_rdy, req_dst, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, busy, tmo_err
  );
  modport slave (
    input  req_rd, req_wr, req_addr, req_din, req_wrmask, sdram_ack, data_rdy, data_dst,
    output req_ack, req_rdy, req_dst, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, busy, tmo_err
  );
endinterface

// File: rtl/jtframe_sdram_rr_arb.sv
// jtframe_sdram_rr_arb: round-robin arbiter sharing one SDRAM controller port between four requesters
module jtframe_sdram_rr_arb #(
  parameter int SDRAMW = 22,
  parameter bit PRIO0  = 1'b0,
  parameter int TMO_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  jtframe_sdram_rr_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_owner, r_rr, w_win;
  logic [TMO_W-1:0] r_cnt;
  logic r_rd, r_wr, r_tmo;
  logic [SDRAMW-1:0] r_addr;
  logic [15:0] r_din;
  logic [1:0] r_mask;
  logic [3:0] w_own, w_pend;
  logic w_acked, w_done, w_grant, w_tmo;
  assign w_own   = 4'b1 << r_owner;
  assign w_acked = r_state == ISSUE && bus.sdram_ack;
  assign w_done  = (r_state == WAIT || w_acked) && bus.data_rdy;
  // the owner still holds its request during its ack cycle, so it cannot be re-granted from ISSUE
  assign w_pend  = (bus.req_rd | bus.req_wr) & (r_state == ISSUE ? ~w_own : 4'hf);
  assign w_grant = |w_pend && (r_state == IDLE || w_done);
  assign w_tmo   = r_state == WAIT && !bus.data_rdy && r_cnt == {{(TMO_W-1){1'b1}}, 1'b0};
  always_comb begin
    w_win = r_rr;
    for (int k = 3; k >= 0; k--)
      if (w_pend[r_rr + 2'(k)]) w_win = r_rr + 2'(k);
    if (PRIO0 && w_pend[0]) w_win = 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = w_grant ? ISSUE :
             (w_done || w_tmo || r_state == IDLE) ? IDLE :
             w_acked ? WAIT : r_state;
  end
  always_comb begin
    bus.req_ack = w_acked ? w_own : 4'h0;
    bus.req_rdy = w_done ? w_own : 4'h0;
    bus.req_dst = (r_state == WAIT && bus.data_dst) ? w_own : 4'h0;
    bus.busy    = r_state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_owner <= 2'd0;
      r_rr    <= 2'd0;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_din   <= 16'h0;
      r_mask  <= 2'b11;
      r_tmo   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_rr    <= w_win + 2'd1;
        r_wr    <= bus.req_wr[w_win];
        r_rd    <= ~bus.req_wr[w_win];
        r_addr  <= bus.req_addr[32'(w_win)*SDRAMW +: SDRAMW];
        r_din   <= bus.req_din[32'(w_win)*16 +: 16];
        r_mask  <= bus.req_wrmask[32'(w_win)*2 +: 2];
      end else if (w_acked) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
      end
      r_cnt <= (r_state == WAIT && !bus.data_rdy) ? r_cnt + 1'b1 : '0;
      if (w_tmo) r_tmo <= 1'b1;
    end
  assign bus.sdram_rd     = r_rd;
  assign bus.sdram_wr     = r_wr;
  assign bus.sdram_addr   = r_addr;
  assign bus.data_write   = r_din;
  assign bus.sdram_wrmask = r_mask;
  assign bus.tmo_err      = r_tmo;
endmodule

// File: tb/tb_jtframe_sdram_rr_arb.sv
// tb_jtframe_sdram_rr_arb: directed and randomized checks of the SDRAM arbiter against a round-robin model
module tb_jtframe_sdram_rr_arb;
  localparam int AW = 22;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int ptr = 0;
  logic [AW-1:0] m_addr [4];
  logic [15:0] m_din [4];
  logic [1:0] m_mask [4];
  logic [3:0] m_rd = 4'h0;
  logic [3:0] m_wr = 4'h0;
  always #5 clk = ~clk;
  jtframe_sdram_rr_arb_if #(.SDRAMW(AW)) b0 ();
  jtframe_sdram_rr_arb_if #(.SDRAMW(AW)) b1 ();
  jtframe_sdram_rr_arb #(.SDRAMW(AW), .PRIO0(1'b0), .TMO_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  jtframe_sdram_rr_arb #(.SDRAMW(AW), .PRIO0(1'b1), .TMO_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // reference arbitration: priority requester 0 if enabled, else first pending from the pointer, modulo 4
  function automatic int pick(input logic [3:0] pend, input int p, input bit prio);
    if (prio && pend[0]) return 0;
    for (int k = 0; k < 4; k++) if (pend[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic sync0;
    b0.req_rd = m_rd;
    b0.req_wr = m_wr;
    for (int n = 0; n < 4; n++) begin
      b0.req_addr[n*AW +: AW] = m_addr[n];
      b0.req_din[n*16 +: 16] = m_din[n];
      b0.req_wrmask[n*2 +: 2] = m_mask[n];
    end
  endtask
  task automatic newreq(input int n);
    int k;
    k = int'($urandom_range(3));
    m_rd[n] = k != 1;
    m_wr[n] = k >= 1;
    m_addr[n] = AW'($urandom);
    m_din[n] = 16'($urandom);
    m_mask[n] = 2'($urandom);
  endtask
  task automatic raise0(input bit force_one);
    for (int n = 0; n < 4; n++)
      if (!(m_rd[n] | m_wr[n]) && $urandom_range(1) == 1) newreq(n);
    if (force_one && (m_rd | m_wr) == 4'h0) newreq(int'($urandom_range(3)));
    sync0;
  endtask
  task automatic clear_in;
    m_rd = 4'h0;
    m_wr = 4'h0;
    for (int n = 0; n < 4; n++) begin
      m_addr[n] = '0;
      m_din[n] = 16'h0;
      m_mask[n] = 2'b11;
    end
    sync0;
    b0.sdram_ack = 1'b0; b0.data_rdy = 1'b0; b0.data_dst = 1'b0;
    b1.req_rd = 4'h0; b1.req_wr = 4'h0; b1.req_addr = '0; b1.req_din = '0; b1.req_wrmask = '1;
    b1.sdram_ack = 1'b0; b1.data_rdy = 1'b0; b1.data_dst = 1'b0;
  endtask
  task automatic do_reset;
    clear_in;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    ptr = 0;
  endtask
  // one full transaction on b0 for expected winner w; leaves data_rdy high so the next grant can follow
  task automatic serve0(input int w, input bit keep, input int ad, input int wd, input bit spawn);
    tick;
    b0.data_rdy = 1'b0;
    ptr = (w + 1) % 4;
    chk("cmd_wr", b0.sdram_wr, m_wr[w]);
    chk("cmd_rd", b0.sdram_rd, !m_wr[w]);
    chk("cmd_addr", b0.sdram_addr, m_addr[w]);
    chk("cmd_data", b0.data_write, m_din[w]);
    chk("cmd_mask", b0.sdram_wrmask, m_mask[w]);
    chk("cmd_busy", b0.busy, 1);
    for (int i = 0; i < ad; i++) begin
      tick;
      chk("cmd_hold", {b0.sdram_rd, b0.sdram_wr, b0.sdram_addr}, {~m_wr[w], m_wr[w], m_addr[w]});
    end
    b0.sdram_ack = 1'b1;
    #1;
    chk("ack", b0.req_ack, 4'b1 << w);
    tick;
    b0.sdram_ack = 1'b0;
    if (!keep) begin
      m_rd[w] = 1'b0;
      m_wr[w] = 1'b0;
      sync0;
    end
    chk("ack_clr", {b0.sdram_rd, b0.sdram_wr}, 2'b00);
    for (int i = 0; i < wd; i++) begin
      tick;
      chk("wait_busy", b0.busy, 1);
    end
    if (spawn) raise0(1'b0);
    b0.data_dst = 1'b1;
    #1;
    chk("dst", b0.req_dst, 4'b1 << w);
    b0.data_dst = 1'b0;
    b0.data_rdy = 1'b1;
    #1;
    chk("rdy", b0.req_rdy, 4'b1 << w);
  endtask
  task automatic idle0;
    tick;
    b0.data_rdy = 1'b0;
    #1;
    chk("idle_busy", b0.busy, 0);
    chk("idle_ack", b0.req_ack, 0);
    chk("idle_rdy", b0.req_rdy, 0);
  endtask
  initial begin
    clear_in;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd", b0.sdram_rd, 0);
    chk("rst_wr", b0.sdram_wr, 0);
    chk("rst_addr", b0.sdram_addr, 0);
    chk("rst_data", b0.data_write, 0);
    chk("rst_mask", b0.sdram_wrmask, 2'b11);
    chk("rst_busy", b0.busy, 0);
    chk("rst_tmo", b0.tmo_err, 0);
    tick;
    rst_n = 1'b1;
    m_rd[1] = 1'b1;
    m_addr[1] = 22'h01234;
    sync0;
    #1;
    chk("pre_ack", b0.req_ack, 0);
    serve0(1, 1'b0, 1, 1, 1'b0);
    idle0;
    m_wr[2] = 1'b1;
    m_din[2] = 16'hBEEF;
    m_mask[2] = 2'b01;
    sync0;
    serve0(2, 1'b0, 0, 2, 1'b0);
    idle0;
    do_reset;
    for (int n = 0; n < 4; n++) m_addr[n] = AW'(32'h100 * (n + 1));
    m_rd = 4'hf;
    sync0;
    for (int i = 0; i < 4; i++) serve0(pick(m_rd | m_wr, ptr, 1'b0), 1'b0, 0, 0, 1'b0);
    idle0;
    m_rd[1] = 1'b1;
    sync0;
    serve0(1, 1'b0, 0, 0, 1'b0);
    idle0;
    m_rd = 4'hf;
    sync0;
    for (int i = 0; i < 4; i++) serve0(pick(m_rd | m_wr, ptr, 1'b0), 1'b0, 0, 0, 1'b0);
    idle0;
    m_rd = 4'b1001;
    sync0;
    for (int i = 0; i < 4; i++) serve0(pick(m_rd | m_wr, ptr, 1'b0), 1'b1, 0, 0, 1'b0);
    m_rd = 4'h0;
    sync0;
    idle0;
    do_reset;
    b1.req_addr[0 +: AW] = 22'h0AAAA;
    b1.req_addr[3*AW +: AW] = 22'h3CCCC;
    b1.req_rd = 4'b1001;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("p0_addr", b1.sdram_addr, 22'h0AAAA);
      chk("p0_rd", b1.sdram_rd, 1);
      b1.sdram_ack = 1'b1;
      #1;
      chk("p0_ack", b1.req_ack, 4'b0001);
      tick;
      b1.sdram_ack = 1'b0;
      b1.data_rdy = 1'b1;
      #1;
      chk("p0_rdy", b1.req_rdy, 4'b0001);
      if (i == 3) b1.req_rd = 4'h0;
      tick;
      b1.data_rdy = 1'b0;
    end
    chk("p0_idle", b1.busy, 0);
    m_rd[3] = 1'b1;
    m_addr[3] = 22'h2ABCD;
    sync0;
    tick;
    chk("same_rd", b0.sdram_rd, 1);
    b0.sdram_ack = 1'b1;
    b0.data_rdy = 1'b1;
    #1;
    chk("same_ack", b0.req_ack, 4'b1000);
    chk("same_rdy", b0.req_rdy, 4'b1000);
    tick;
    b0.sdram_ack = 1'b0;
    b0.data_rdy = 1'b0;
    m_rd[3] = 1'b0;
    sync0;
    chk("same_idle", b0.busy, 0);
    chk("same_cmd", b0.sdram_rd, 0);
    do_reset;
    m_rd[0] = 1'b1;
    sync0;
    tick;
    b0.sdram_ack = 1'b1;
    tick;
    b0.sdram_ack = 1'b0;
    m_rd[0] = 1'b0;
    sync0;
    for (int i = 0; i < 14; i++) tick;
    chk("tmo_pre_busy", b0.busy, 1);
    chk("tmo_pre_err", b0.tmo_err, 0);
    tick;
    chk("tmo_err", b0.tmo_err, 1);
    chk("tmo_idle", b0.busy, 0);
    b0.data_rdy = 1'b1;
    #1;
    chk("tmo_late_rdy", b0.req_rdy, 0);
    b0.data_rdy = 1'b0;
    m_rd[1] = 1'b1;
    m_addr[1] = 22'h3FFFF;
    sync0;
    tick;
    chk("mid_rd", b0.sdram_rd, 1);
    chk("tmo_sticky", b0.tmo_err, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", b0.sdram_rd, 0);
    chk("mid_rst_addr", b0.sdram_addr, 0);
    chk("mid_rst_mask", b0.sdram_wrmask, 2'b11);
    chk("mid_rst_busy", b0.busy, 0);
    chk("mid_rst_tmo", b0.tmo_err, 0);
    do_reset;
    m_rd[0] = 1'b1;
    sync0;
    tick;
    b0.sdram_ack = 1'b1;
    tick;
    b0.sdram_ack = 1'b0;
    m_rd[0] = 1'b0;
    sync0;
    for (int i = 0; i < 14; i++) tick;
    b0.data_rdy = 1'b1;
    #1;
    chk("tie_rdy", b0.req_rdy, 4'b0001);
    tick;
    b0.data_rdy = 1'b0;
    chk("tie_tmo", b0.tmo_err, 0);
    chk("tie_idle", b0.busy, 0);
    do_reset;
    raise0(1'b1);
    for (int t = 0; t < 40; t++) begin
      serve0(pick(m_rd | m_wr, ptr, 1'b0), 1'b0, int'($urandom_range(2)), int'($urandom_range(3)), 1'b1);
      if ((m_rd | m_wr) == 4'h0) begin
        idle0;
        raise0(1'b1);
      end
    end
    m_rd = 4'h0;
    m_wr = 4'h0;
    sync0;
    idle0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
